// File: rtl/gpio_led_pwm_if.sv
// PS-side write port and LED outputs of the gpio_led_pwm channel driver.
interface gpio_led_pwm_if #(
    parameter int unsigned N_LED    = 4,
    parameter int unsigned PWM_BITS = 8
);
    localparam int unsigned CH_W = (N_LED > 1) ? $clog2(N_LED) : 1;

    logic                wr_en;
    logic [CH_W-1:0]     wr_ch;
    logic [1:0]          wr_mode;
    logic [PWM_BITS-1:0] wr_duty;
    logic [N_LED-1:0]    led;
    logic                period_start;

    modport master (
        output wr_en, wr_ch, wr_mode, wr_duty,
        input  led, period_start
    );

    modport slave (
        input  wr_en, wr_ch, wr_mode, wr_duty,
        output led, period_start
    );
endinterface

// File: rtl/gpio_led_pwm.sv
// Multi-channel LED driver: off/on/PWM/PWM-blink per channel, with channel
// config double-buffered and committed at every PWM period boundary.
// Optional macro LED_GAMMA_EN: squares the duty (duty*duty >> PWM_BITS) at commit.
module gpio_led_pwm #(
    parameter int unsigned N_LED        = 4,
    parameter int unsigned PWM_BITS     = 8,
    parameter int unsigned PWM_PRESCALE = 390,
    parameter int unsigned BLINK_HALF   = 50000000
) (
    input  logic           FCLK_CLK0,
    input  logic           FCLK_RESET0_N,
    gpio_led_pwm_if.slave  bus
);
    localparam int unsigned CH_W   = (N_LED > 1) ? $clog2(N_LED) : 1;
    localparam int unsigned PRE_W  = (PWM_PRESCALE > 1) ? $clog2(PWM_PRESCALE) : 1;
    localparam int unsigned BLK_W  = $clog2(BLINK_HALF);
    localparam int unsigned PROD_W = 2 * PWM_BITS;

    typedef enum logic [1:0] {
        MODE_OFF   = 2'b00,
        MODE_ON    = 2'b01,
        MODE_PWM   = 2'b10,
        MODE_BLINK = 2'b11
    } mode_e;

    typedef struct packed {
        mode_e               mode;
        logic [PWM_BITS-1:0] duty;
    } ch_cfg_t;

    logic [PRE_W-1:0]    pre_cnt_q, pre_cnt_d;
    logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
    logic [BLK_W-1:0]    blink_cnt_q, blink_cnt_d;
    logic                blink_phase_q, blink_phase_d;
    ch_cfg_t [N_LED-1:0] pend_q, pend_d;
    ch_cfg_t [N_LED-1:0] act_q, act_d;
    logic [N_LED-1:0]    led_q, led_d;
    logic                period_start_q, period_start_d;
    logic                tick;
    logic                wrap;

    // Duty as seen by the comparator; gamma correction folds into the commit.
    function automatic logic [PWM_BITS-1:0] eff_duty(input logic [PWM_BITS-1:0] d);
`ifdef LED_GAMMA_EN
        logic [PROD_W-1:0] prod;
        prod = PROD_W'(d) * PROD_W'(d);
        return prod[PROD_W-1:PWM_BITS];
`else
        return d;
`endif
    endfunction

    // Prescaler, PWM counter and free-running blink timer.
    always_comb begin
        tick          = (pre_cnt_q == PRE_W'(PWM_PRESCALE - 1));
        wrap          = tick && (pwm_cnt_q == {PWM_BITS{1'b1}});
        pre_cnt_d     = tick ? '0 : pre_cnt_q + PRE_W'(1);
        pwm_cnt_d     = tick ? pwm_cnt_q + PWM_BITS'(1) : pwm_cnt_q;
        blink_cnt_d   = blink_cnt_q + BLK_W'(1);
        blink_phase_d = blink_phase_q;
        if (blink_cnt_q == BLK_W'(BLINK_HALF - 1)) begin
            blink_cnt_d   = '0;
            blink_phase_d = ~blink_phase_q;
        end
        period_start_d = wrap;
    end

    // Pending load on write; commit from the post-write pending so a write on wrap bypasses.
    always_comb begin
        pend_d = pend_q;
        act_d  = act_q;
        for (int unsigned i = 0; i < N_LED; i++) begin
            if (bus.wr_en && (bus.wr_ch == CH_W'(i))) begin
                pend_d[i].mode = mode_e'(bus.wr_mode);
                pend_d[i].duty = bus.wr_duty;
            end
            if (wrap) begin
                act_d[i].mode = pend_d[i].mode;
                act_d[i].duty = eff_duty(pend_d[i].duty);
            end
        end
    end

    // Per-channel LED level from active config and current counters.
    always_comb begin
        led_d = '0;
        for (int unsigned i = 0; i < N_LED; i++) begin
            case (act_q[i].mode)
                MODE_OFF:   led_d[i] = 1'b0;
                MODE_ON:    led_d[i] = 1'b1;
                MODE_PWM:   led_d[i] = (pwm_cnt_q < act_q[i].duty);
                MODE_BLINK: led_d[i] = blink_phase_q && (pwm_cnt_q < act_q[i].duty);
                default:    led_d[i] = 1'b0;
            endcase
        end
    end

    // State registers.
    always_ff @(posedge FCLK_CLK0 or negedge FCLK_RESET0_N) begin
        if (!FCLK_RESET0_N) begin
            pre_cnt_q      <= '0;
            pwm_cnt_q      <= '0;
            blink_cnt_q    <= '0;
            blink_phase_q  <= 1'b0;
            pend_q         <= '0;
            act_q          <= '0;
            led_q          <= '0;
            period_start_q <= 1'b0;
        end else begin
            pre_cnt_q      <= pre_cnt_d;
            pwm_cnt_q      <= pwm_cnt_d;
            blink_cnt_q    <= blink_cnt_d;
            blink_phase_q  <= blink_phase_d;
            pend_q         <= pend_d;
            act_q          <= act_d;
            led_q          <= led_d;
            period_start_q <= period_start_d;
        end
    end

    assign bus.led          = led_q;
    assign bus.period_start = period_start_q;

endmodule

// File: tb/tb_gpio_led_pwm.sv
// Scoreboard bench for gpio_led_pwm: stimulus pushes the reference model's
// expected {led, period_start} per cycle; a monitor pops and compares.
module tb_gpio_led_pwm;
    localparam int unsigned N_LED        = 3;
    localparam int unsigned PWM_BITS     = 4;
    localparam int unsigned PWM_PRESCALE = 2;
    localparam int unsigned BLINK_HALF   = 8;
    localparam int unsigned CH_W         = 2;
    localparam int unsigned PMAX         = 16;

    logic clk = 1'b0;
    logic rst_n;

    always #5 clk = ~clk;

    gpio_led_pwm_if #(.N_LED(N_LED), .PWM_BITS(PWM_BITS)) bus ();

    gpio_led_pwm #(
        .N_LED(N_LED), .PWM_BITS(PWM_BITS),
        .PWM_PRESCALE(PWM_PRESCALE), .BLINK_HALF(BLINK_HALF)
    ) dut (
        .FCLK_CLK0(clk),
        .FCLK_RESET0_N(rst_n),
        .bus(bus.slave)
    );

    // Reference model: cycles since reset plus pending/active channel tables.
    int unsigned k;
    int          p_mode [N_LED];
    int          p_duty [N_LED];
    int          a_mode [N_LED];
    int          a_duty [N_LED];
    logic [N_LED:0] exp_q [$];
    int vectors     = 0;
    int miscompares = 0;

    function automatic int pwm_of(input int unsigned c);
        return int'((c / PWM_PRESCALE) % PMAX);
    endfunction

    function automatic bit phase_of(input int unsigned c);
        return ((c / BLINK_HALF) % 2) == 1;
    endfunction

    function automatic bit wrap_of(input int unsigned c);
        return ((c % PWM_PRESCALE) == PWM_PRESCALE - 1) && (pwm_of(c) == int'(PMAX) - 1);
    endfunction

    function automatic int eff(input int d);
`ifdef LED_GAMMA_EN
        return (d * d) / int'(PMAX);
`else
        return d;
`endif
    endfunction

    task automatic model_reset();
        k = 0;
        for (int i = 0; i < int'(N_LED); i++) begin
            p_mode[i] = 0; p_duty[i] = 0; a_mode[i] = 0; a_duty[i] = 0;
        end
    endtask

    // Drive this cycle's inputs and push what the outputs must be after the edge.
    task automatic drive_and_push(input bit en, input int ch, input int mode, input int duty);
        logic [N_LED-1:0] e_led;
        int pc;
        bit ph;
        bus.wr_en   = en;
        bus.wr_ch   = CH_W'(ch);
        bus.wr_mode = 2'(mode);
        bus.wr_duty = PWM_BITS'(duty);
        pc = pwm_of(k);
        ph = phase_of(k);
        e_led = '0;
        for (int i = 0; i < int'(N_LED); i++) begin
            case (a_mode[i])
                1:       e_led[i] = 1'b1;
                2:       e_led[i] = (pc < a_duty[i]);
                3:       e_led[i] = ph && (pc < a_duty[i]);
                default: e_led[i] = 1'b0;
            endcase
        end
        exp_q.push_back({e_led, wrap_of(k)});
        if (en && ch < int'(N_LED)) begin
            p_mode[ch] = mode;
            p_duty[ch] = duty;
        end
        if (wrap_of(k)) begin
            for (int i = 0; i < int'(N_LED); i++) begin
                a_mode[i] = p_mode[i];
                a_duty[i] = eff(p_duty[i]);
            end
        end
        k++;
    endtask

    task automatic step(input bit en, input int ch, input int mode, input int duty);
        @(negedge clk);
        #1;
        drive_and_push(en, ch, mode, duty);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 0, 0, 0);
    endtask

    task automatic check_now(input string name, input logic [N_LED:0] got, input logic [N_LED:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s: got led/ps=%b required %b", name, got, want);
        end
    endtask

    // Monitor: every sampled cycle is compared with the oldest expectation.
    initial begin
        logic [N_LED:0] e;
        logic [N_LED:0] got;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e   = exp_q.pop_front();
                got = {bus.led, bus.period_start};
                vectors++;
                if (got !== e) begin
                    miscompares++;
                    $display("FAIL out k=%0d: got led=%b ps=%b required led=%b ps=%b",
                             k, got[N_LED:1], got[0], e[N_LED:1], e[0]);
                end
            end
        end
    end

    initial begin
        bus.wr_en = 1'b0; bus.wr_ch = '0; bus.wr_mode = '0; bus.wr_duty = '0;
        model_reset();
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #10;
        check_now("reset_state", {bus.led, bus.period_start}, '0);
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        drive_and_push(1'b0, 0, 0, 0);

        // ch0 PWM duty 4, then several periods
        step(1'b1, 0, 2, 4);
        idle(70);
        // ch1 PWM duty 12 written mid-period
        idle(9);
        step(1'b1, 1, 2, 12);
        idle(70);
        // write coincident with wrap bypasses into active
        while (!wrap_of(k)) step(1'b0, 0, 0, 0);
        step(1'b1, 1, 2, 5);
        idle(40);
        // ch2 blink duty 15, then on, then off
        step(1'b1, 2, 3, 15);
        idle(100);
        step(1'b1, 2, 1, 0);
        idle(40);
        step(1'b1, 2, 0, 7);
        idle(40);
        // out-of-range channel ignored; last write wins
        step(1'b1, 3, 1, 9);
        step(1'b1, 0, 2, 2);
        step(1'b1, 0, 2, 9);
        idle(40);
        // duty 8 (gamma gives 4) and full duty
        step(1'b1, 1, 2, 8);
        step(1'b1, 2, 2, 15);
        idle(40);
        // randomized writes
        for (int i = 0; i < 400; i++) begin
            step(($urandom % 6) == 0, int'($urandom % 4), int'($urandom % 4), int'($urandom % PMAX));
        end
        // force a lit LED, then reset mid-period
        step(1'b1, 0, 1, 0);
        idle(40);
        @(negedge clk);
        #1;
        bus.wr_en = 1'b0;
        rst_n = 1'b0;
        #1;
        check_now("async_reset", {bus.led, bus.period_start}, '0);
        repeat (2) @(posedge clk);
        #1;
        check_now("reset_hold", {bus.led, bus.period_start}, '0);
        @(negedge clk);
        #1;
        model_reset();
        rst_n = 1'b1;
        drive_and_push(1'b0, 0, 0, 0);
        idle(40);
        for (int i = 0; i < 150; i++) begin
            step(($urandom % 5) == 0, int'($urandom % 4), int'($urandom % 4), int'($urandom % PMAX));
        end
        @(negedge clk);
        #1;
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
